// File: rtl/inst_decode_pipe.sv
// Multi-beat draw/alpha instruction decoder with a valid/ready output register.
// Optional perf counters are enabled with `define DECODE_PERF_EN. Requires BEATS >= 2.
module inst_decode_pipe #(
  parameter int WORD_W    = 32,
  parameter int COORD_W   = 8,
  parameter int MAX_VERTS = 4,
  parameter int LAYER_W   = 2,
  parameter int TEX_W     = 2,
  parameter int ALPHA_W   = 4,
  localparam int VCNT_W   = $clog2(MAX_VERTS + 1),
  localparam int CRD_W    = 2 * COORD_W * MAX_VERTS,
  localparam int INST_W   = 1 + VCNT_W + CRD_W + LAYER_W + 1 + 24 + TEX_W + ALPHA_W,
  localparam int BEATS    = (INST_W + WORD_W - 1) / WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  output logic               draw_valid,
  input  logic               draw_ready,
  output logic [CRD_W-1:0]   coordinates,
  output logic [VCNT_W-1:0]  vertice_num,
  output logic [LAYER_W-1:0] layer_num,
  output logic               fill_type,
  output logic [23:0]        color_code,
  output logic [TEX_W-1:0]   texture_code,
  output logic [ALPHA_W-1:0] alpha_val,
  output logic               err_vcnt,
  output logic [15:0]        draw_cnt,
  output logic [15:0]        alpha_cnt,
  output logic [15:0]        err_cnt
);

  localparam int OFF_VCNT  = 1;
  localparam int OFF_CRD   = OFF_VCNT + VCNT_W;
  localparam int OFF_LAYER = OFF_CRD + CRD_W;
  localparam int OFF_FILL  = OFF_LAYER + LAYER_W;
  localparam int OFF_COLOR = OFF_FILL + 1;
  localparam int OFF_TEX   = OFF_COLOR + 24;
  localparam int OFF_ALPHA = OFF_TEX + TEX_W;
  localparam int BUF_W     = (BEATS - 1) * WORD_W;
  localparam int BCNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VSLOT_W   = 2 * COORD_W;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  typedef enum logic {S_IDLE, S_ASM} state_t;

  function automatic logic [ALPHA_W-1:0] resolve_alpha(input logic [ALPHA_W-1:0] fld,
                                                       input logic [ALPHA_W-1:0] sticky);
    return (fld == '0) ? sticky : fld;
  endfunction

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BUF_W-1:0]    buf_q;
  logic [ALPHA_W-1:0]  alpha_reg_q;
  logic                draw_valid_q, draw_valid_d;
  logic                err_q;
  logic [CRD_W-1:0]    crd_q, crd_d;
  logic [VCNT_W-1:0]   vcnt_q;
  logic [LAYER_W-1:0]  layer_q;
  logic                fill_q;
  logic [23:0]         color_q, color_d;
  logic [TEX_W-1:0]    tex_q, tex_d;
  logic [ALPHA_W-1:0]  alpha_q, alpha_d;

  logic                out_free, rd_c, alpha_pop, beat_wr, final_pop, load, drop;
  logic [BEATS*WORD_W-1:0] full_w;
  logic [VCNT_W-1:0]   dec_vcnt;
  logic                dec_fill, vcnt_ok;
  logic                unused_bits;

  // Control: sequencing of beats and the final-beat back-pressure rule
  always_comb begin
    out_free   = !draw_valid_q || draw_ready;
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    rd_c       = 1'b0;
    alpha_pop  = 1'b0;
    beat_wr    = 1'b0;
    final_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          rd_c = 1'b1;
          if (fifo_data[0]) begin
            alpha_pop = 1'b1;
          end else begin
            beat_wr    = 1'b1;
            state_d    = S_ASM;
            beat_cnt_d = BCNT_W'(1);
          end
        end
      end
      S_ASM: begin
        if (!fifo_empty) begin
          if (beat_cnt_q == LAST_BEAT) begin
            if (out_free) begin
              rd_c       = 1'b1;
              final_pop  = 1'b1;
              state_d    = S_IDLE;
              beat_cnt_d = '0;
            end
          end else begin
            rd_c       = 1'b1;
            beat_wr    = 1'b1;
            beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_rd = rd_c && !rst;

  // Decode: the final beat is used straight from the FIFO head
  always_comb begin
    full_w   = {fifo_data, buf_q};
    dec_vcnt = full_w[OFF_VCNT +: VCNT_W];
    dec_fill = full_w[OFF_FILL];
    vcnt_ok  = (dec_vcnt >= VCNT_W'(2)) && (dec_vcnt <= VCNT_W'(MAX_VERTS));
    crd_d    = '0;
    for (int i = 0; i < MAX_VERTS; i++) begin
      if (i < int'(dec_vcnt)) crd_d[i*VSLOT_W +: VSLOT_W] = full_w[OFF_CRD + i*VSLOT_W +: VSLOT_W];
    end
    color_d      = dec_fill ? 24'd0 : full_w[OFF_COLOR +: 24];
    tex_d        = dec_fill ? full_w[OFF_TEX +: TEX_W] : '0;
    alpha_d      = resolve_alpha(full_w[OFF_ALPHA +: ALPHA_W], alpha_reg_q);
    load         = final_pop && vcnt_ok;
    drop         = final_pop && !vcnt_ok;
    draw_valid_d = load || (draw_valid_q && !draw_ready);
  end

  assign unused_bits = ^full_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      draw_valid_q <= 1'b0;
      err_q        <= 1'b0;
      alpha_reg_q  <= '1;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      draw_valid_q <= draw_valid_d;
      err_q        <= drop;
      if (alpha_pop) alpha_reg_q <= fifo_data[ALPHA_W:1];
    end
  end

  // Assembly buffer holds beats 0..BEATS-2; contents are don't-care outside ASSEMBLE
  always_ff @(posedge clk) begin
    if (beat_wr) buf_q[int'(beat_cnt_q)*WORD_W +: WORD_W] <= fifo_data;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      crd_q   <= '0;
      vcnt_q  <= '0;
      layer_q <= '0;
      fill_q  <= 1'b0;
      color_q <= '0;
      tex_q   <= '0;
      alpha_q <= '0;
    end else if (load) begin
      crd_q   <= crd_d;
      vcnt_q  <= dec_vcnt;
      layer_q <= full_w[OFF_LAYER +: LAYER_W];
      fill_q  <= dec_fill;
      color_q <= color_d;
      tex_q   <= tex_d;
      alpha_q <= alpha_d;
    end
  end

  assign draw_valid   = draw_valid_q;
  assign coordinates  = crd_q;
  assign vertice_num  = vcnt_q;
  assign layer_num    = layer_q;
  assign fill_type    = fill_q;
  assign color_code   = color_q;
  assign texture_code = tex_q;
  assign alpha_val    = alpha_q;
  assign err_vcnt     = err_q;

`ifdef DECODE_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] draw_cnt_q, alpha_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      draw_cnt_q  <= '0;
      alpha_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (load)      draw_cnt_q  <= sat_inc(draw_cnt_q);
      if (alpha_pop) alpha_cnt_q <= sat_inc(alpha_cnt_q);
      if (drop)      err_cnt_q   <= sat_inc(err_cnt_q);
    end
  end

  assign draw_cnt  = draw_cnt_q;
  assign alpha_cnt = alpha_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign draw_cnt  = '0;
  assign alpha_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: doc/inst_decode_pipe.md
# inst_decode_pipe

Parametrised, registered successor to the single-word instruction decoder. It assembles draw instructions that arrive over several narrow FIFO words (beats) and resolves vertex count up to `MAX_VERTS`. It keeps a sticky global alpha that single-beat alpha instructions update, and presents each decoded draw on a valid/ready output register. It sits between the command FIFO and the rasteriser front end.

## Interface
- `WORD_W`, 32: FIFO word width.
- `COORD_W`, 8: width of one X or Y coordinate.
- `MAX_VERTS`, 4: maximum vertices per draw; minimum legal is 2.
- `LAYER_W`, 2: layer number width.
- `TEX_W`, 2: texture code width.
- `ALPHA_W`, 4: alpha width.
- Derived: `VCNT_W=$clog2(MAX_VERTS+1)`; `INST_W=1+VCNT_W+2*COORD_W*MAX_VERTS+LAYER_W+1+24+TEX_W+ALPHA_W` (101 at defaults); `BEATS=ceil(INST_W/WORD_W)` (4 at defaults).

- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `fifo_data`  in  WORD_W  head word of a first-word-fall-through FIFO; valid while `!fifo_empty`.
- `fifo_empty`  in  1  FIFO empty.
- `fifo_rd`  out  1  pops the head word this cycle.
- `draw_valid`  out  1  decoded draw held in the output register.
- `draw_ready`  in  1  consumer accepts the draw.
- `coordinates`  out  2*COORD_W*MAX_VERTS  vertex i at `[2*COORD_W*i +: 2*COORD_W]` as {Y,X}; unused slots are 0.
- `vertice_num`  out  VCNT_W  vertex count, 2..MAX_VERTS.
- `layer_num`  out  LAYER_W  layer.
- `fill_type`  out  1  0 = solid, 1 = texture.
- `color_code`  out  24  colour; forced 0 when `fill_type=1`.
- `texture_code`  out  TEX_W  texture; forced 0 when `fill_type=0`.
- `alpha_val`  out  ALPHA_W  resolved alpha for this draw.
- `err_vcnt`  out  1  one-cycle pulse when an illegal vertex count is dropped.
- `draw_cnt`, `alpha_cnt`, `err_cnt`  out  16 each  perf counters (see Configuration).

## Operation
- Instruction bits are concatenated LSB-first. Beat k carries bits `[k*WORD_W +: WORD_W]`. Bit 0 of beat 0 is `inst_type`.
- Draw field order from bit 1 up: vcnt, coords (vertex 0 first, X low), layer, fill_type, colour, texture, alpha.
- Alpha instruction (`inst_type=1`): a single beat. `alpha_reg <= beat0[ALPHA_W:1]`. The beat is always popped when the FIFO is non-empty and the block is in IDLE. It does not touch the output register.
- Draw instruction: BEATS beats.
  - IDLE: head word with bit0=0 is popped into the assembly buffer; go to ASSEMBLE with `beat_cnt=1`.
  - ASSEMBLE: pop one beat per cycle while the FIFO is non-empty. Empty cycles stall; no timeout.
  - On the final beat (`beat_cnt=BEATS-1`), decode the full word and return to IDLE.
- Final-beat rule: the final beat is popped only if the output register is free (`!draw_valid || draw_ready`). Earlier beats are popped regardless of output state.
- Decode:
  - Vcnt outside 2..MAX_VERTS: drop the instruction, pulse `err_vcnt`, leave the output register unchanged.
  - Otherwise load the output register. Coordinate slots at index ≥ vcnt are zeroed.
  - If the draw's alpha field is 0, `alpha_val = alpha_reg`; otherwise the field is used as-is.
  - Alpha is resolved at final-beat pop, so an alpha instruction popped later does not affect an already-latched draw.
- Output handshake: `draw_valid` stays high and all outputs stay stable until `draw_valid && draw_ready`. If a new final beat is popped in that same cycle, the register reloads with no bubble.

## Timing
- Reset values: `fifo_rd=0`, `draw_valid=0`, all data outputs 0, `err_vcnt=0`, counters 0, `alpha_reg=all-ones` (opaque), state IDLE, `beat_cnt=0`.
- Reset mid-assembly discards partial beats; already-popped words are lost.
- `fifo_rd` is combinational from state, `fifo_empty`, `draw_valid` and `draw_ready`.
- Latency: final beat popped in cycle N → `draw_valid=1` and data visible in cycle N+1.
- Alpha beat popped in cycle N → `alpha_reg` updated in N+1.
- `err_vcnt` is high in cycle N+1 only.
- Peak throughput: one draw per BEATS cycles; one alpha instruction per cycle.
- `beat_cnt` width is `$clog2(BEATS)`, minimum 1 bit. The counter wraps to 0 on leaving ASSEMBLE.

## Configuration
- `DECODE_PERF_EN` defined: `draw_cnt`, `alpha_cnt` and `err_cnt` increment on each accepted draw decode, alpha pop and dropped draw respectively. Each is 16-bit and saturates at 16'hFFFF. All clear on `rst`.
- `DECODE_PERF_EN` undefined: the three ports still exist but are tied to 0 and no counter logic is generated.

## Test plan
- Reset then one 4-beat draw: vcnt=3, coords (1,2),(3,4),(5,6), layer 2, solid colour 24'hABCDEF, alpha field 0 → `draw_valid` one cycle after beat 3. Expect `alpha_val=4'hF`, slot 3 = 0, `texture_code=0`.
- Alpha word with alpha=4'h5, then a draw with alpha field 0 → `alpha_val=4'h5`. A following draw with alpha field 4'h9 → `alpha_val=4'h9`.
- Draw with vcnt=1, then with vcnt=5 → two `err_vcnt` pulses and no `draw_valid`. With `DECODE_PERF_EN`, `err_cnt=2`.
- Hold `draw_ready=0` with a second complete draw queued → beats 0-2 are popped, beat 3 is held, outputs stay stable. Raise `draw_ready` → beat 3 is popped that cycle and the new draw appears the next cycle with no bubble.
- `fifo_empty` toggled every other cycle during assembly → draw is correct; `fifo_rd` is never high while empty.
- Assert `rst` after beat 1 of a draw, then send a full new draw → only the new draw is output and `alpha_val` resolves to 4'hF.
